fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch controller that owns the program counter and sequences every fetch. Issues one outstanding request at a time to instruction memory over a valid/ready handshake and selects the next PC from sequential increment, branch-predictor target, or execute-stage redirect. Buffers one returned instruction for decode and discards responses made stale by a redirect. Sits between the branch predictor, instruction memory and decode.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset
- XLEN, 32: address/instruction width
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- bp_pc  out  XLEN  current PC, presented to the predictor for same-cycle lookup
- bp_taken  in  1  predictor says taken for bp_pc
- bp_target  in  XLEN  predicted target for bp_pc
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  response valid, ≥1 cycle after acceptance, exactly one per accepted request
- imem_rsp_data  in  XLEN  instruction word
- if_valid  out  1  buffered instruction valid to decode
- id_ready  in  1  decode consumes when if_valid && id_ready
- if_instr, if_pc, if_pred_target  out  XLEN  buffered instruction, its PC, predicted next PC
- if_pred_taken  out  1  prediction used for this instruction
- ex_redirect  in  1  mispredict/jump resolution, one-cycle pulse
- ex_target  in  XLEN  correct next PC

## Operation
- States: IDLE, REQ, WAIT, DRAIN (enum in package).
- IDLE: only entered by reset; next cycle → REQ.
- REQ: imem_req_valid = 1 when buffer empty or being consumed this cycle (!if_valid || id_ready); else 0 and stay. On accept (valid && ready): latch pc, bp_taken, chosen next PC into in-flight slot; pc <= bp_taken ? bp_target : pc + 4; → WAIT.
- WAIT: on imem_rsp_valid load buffer {data, in-flight pc, taken, next PC}, set if_valid; → REQ.
- DRAIN: stale request outstanding; on imem_rsp_valid drop data, → REQ.
- Redirect (highest priority, any state): pc <= ex_target; if_valid cleared same edge; no further fetch from old path.
  - REQ without accept, or WAIT with rsp_valid same cycle (response dropped) → REQ.
  - REQ with accept same cycle, or WAIT without response → DRAIN.
  - DRAIN → stays DRAIN (still one stale response); IDLE → REQ.
- Consume: if_valid && id_ready and no new load → if_valid <= 0. Load and consume same cycle → buffer holds new entry.
- Width rules: pc+4 wraps modulo 2^XLEN; pc[1:0], bp_target[1:0], ex_target[1:0] forced to 0 when loaded.

## Timing
- Reset values: state IDLE, pc = RESET_PC, imem_req_valid 0, if_valid 0, if_instr/if_pc/if_pred_target 0, if_pred_taken 0.
- bp_pc, imem_req_addr, imem_req_valid combinational from registered pc/state/if_valid plus id_ready; no combinational path from imem_req_ready to imem_req_valid.
- Latency: accept at cycle N, response at N+k (k≥1), if_valid at N+k+1. Peak throughput one instruction per 2 cycles with k=1.
- Redirect at cycle N: first request to ex_target at N+1 if no stale response pending, else one cycle after stale response arrives.
- Reset asserted mid-operation: all state returns to reset values immediately; an in-flight memory response arriving after reset deasserts is not tracked (memory is reset together).

## Structure
- fetch_pkg: state enum fetch_state_t, INSTR_BYTES = 4, XLEN default.
- One sub-module: fetch_out_buf (one-entry decode buffer with load/consume/flush); FSM and pc register stay in fetch_ctrl.

## Test plan
- Reset with RESET_PC=0x100, ready=1, 1-cycle memory, predictor not-taken, id_ready=1 -> requests 0x100,0x104,0x108 every 2 cycles; if_pc matches, if_pred_target = pc+4.
- bp_taken=1, bp_target=0x203 at pc 0x104 -> next request 0x200; buffered entry pc 0x104, pred_taken 1, pred_target 0x200.
- id_ready=0 for 5 cycles with if_valid=1 -> no new request, if_instr stable; id_ready=1 -> request issued same cycle.
- ex_redirect to 0x400 in WAIT, response 2 cycles later -> response dropped, if_valid stays 0, next request 0x400.
- ex_redirect coincident with imem_rsp_valid -> response dropped, request 0x400 next cycle; coincident with accept -> DRAIN, one stale response discarded.
- pc=0xFFFF_FFFC sequential -> next request 0x0000_0000; reset asserted in WAIT -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_buf.sv
// One-entry decode buffer: holds a fetched instruction with its PC and prediction.
module fetch_out_buf import fetch_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            consume,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic            load_taken,
  input  logic [XLEN-1:0] load_target,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target
);

  logic            valid_r;
  logic [XLEN-1:0] instr_r;
  logic [XLEN-1:0] pc_r;
  logic            taken_r;
  logic [XLEN-1:0] target_r;

  // Flush beats load beats consume; a load while consuming keeps the new entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r  <= 1'b0;
      instr_r  <= '0;
      pc_r     <= '0;
      taken_r  <= 1'b0;
      target_r <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r  <= 1'b1;
      instr_r  <= load_instr;
      pc_r     <= load_pc;
      taken_r  <= load_taken;
      target_r <= load_target;
    end else if (valid_r && consume) begin
      valid_r <= 1'b0;
    end
  end

  assign if_valid       = valid_r;
  assign if_instr       = instr_r;
  assign if_pc          = pc_r;
  assign if_pred_taken  = taken_r;
  assign if_pred_target = target_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one outstanding imem request
// at a time, and drops responses made stale by an execute-stage redirect.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] bp_pc,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pred_target,
  output logic            if_pred_taken,
  input  logic            ex_redirect,
  input  logic [XLEN-1:0] ex_target
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

  fetch_state_t    state_r;
  fetch_state_t    state_next_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] pred_next_s;
  logic [XLEN-1:0] fl_pc_r;
  logic            fl_taken_r;
  logic [XLEN-1:0] fl_next_r;
  logic            req_valid_s;
  logic            accept_s;
  logic            buf_load_s;

  // Request only when the decode buffer will have room at the next edge.
  assign req_valid_s = (state_r == REQ) && (!if_valid || id_ready);
  assign accept_s    = req_valid_s && imem_req_ready;
  assign pred_next_s = bp_taken ? align_word(bp_target) : (pc_r + PC_STEP);

  assign bp_pc          = pc_r;
  assign imem_req_addr  = pc_r;
  assign imem_req_valid = req_valid_s;

  // State and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
    end
  end

  // In-flight slot: PC and prediction of the request memory just accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fl_pc_r    <= '0;
      fl_taken_r <= 1'b0;
      fl_next_r  <= '0;
    end else if (accept_s) begin
      fl_pc_r    <= pc_r;
      fl_taken_r <= bp_taken;
      fl_next_r  <= pred_next_s;
    end
  end

  // Next-state and next-PC selection; a redirect overrides everything else.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    buf_load_s   = 1'b0;
    if (ex_redirect) begin
      pc_next_s = align_word(ex_target);
      case (state_r)
        IDLE:    state_next_s = REQ;
        REQ:     state_next_s = accept_s ? DRAIN : REQ;
        WAIT:    state_next_s = imem_rsp_valid ? REQ : DRAIN;
        DRAIN:   state_next_s = imem_rsp_valid ? REQ : DRAIN;
        default: state_next_s = IDLE;
      endcase
    end else begin
      case (state_r)
        IDLE: state_next_s = REQ;
        REQ: begin
          if (accept_s) begin
            pc_next_s    = pred_next_s;
            state_next_s = WAIT;
          end else begin
            state_next_s = REQ;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            buf_load_s   = 1'b1;
            state_next_s = REQ;
          end else begin
            state_next_s = WAIT;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) begin
            state_next_s = REQ;
          end else begin
            state_next_s = DRAIN;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  fetch_out_buf #(.XLEN(XLEN)) u_out_buf (
    .clk            (clk),
    .reset          (reset),
    .load           (buf_load_s),
    .flush          (ex_redirect),
    .consume        (id_ready),
    .load_instr     (imem_rsp_data),
    .load_pc        (fl_pc_r),
    .load_taken     (fl_taken_r),
    .load_target    (fl_next_r),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target)
  );

endmodule
